// File: rtl/axi_stream_pkg.sv
// Shared widths, lane count, FSM encoding and lane-keep reduction
// for the AXI-Stream to sorter-FIFO read path.
package axi_stream_pkg;

  localparam int AXIS_DW     = 512;
  localparam int SORT_W      = 128;
  localparam int N_LANES     = AXIS_DW / SORT_W;
  localparam int LANE_KB_MAX = 64;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_UNPACK = 1'b1
  } rd_state_t;

  function automatic logic lane_kept(
    input logic [LANE_KB_MAX-1:0] kb
  );
    return |kb;
  endfunction

endpackage

// File: rtl/axis_lane_select.sv
// Picks lane ptr out of the buffered beat and reports whether
// any of its tkeep bytes is set.
module axis_lane_select
  import axi_stream_pkg::*;
#(
  parameter int DW = AXIS_DW,
  parameter int SW = SORT_W,
  parameter int N  = DW / SW,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [DW-1:0]   i_data,
  input  logic [DW/8-1:0] i_keep,
  input  logic [PW-1:0]   i_ptr,
  output logic [SW-1:0]   o_item,
  output logic            o_kept
);

  localparam int KB = SW / 8;

  logic [SW-1:0] w_item [N];
  logic [N-1:0]  w_kept;

  for (genvar g = 0; g < N; g++) begin : g_lane
    assign w_item[g] = i_data[g*SW +: SW];
    assign w_kept[g] =
      lane_kept(LANE_KB_MAX'(i_keep[g*KB +: KB]));
  end

  assign o_item = w_item[i_ptr];
  assign o_kept = w_kept[i_ptr];

endmodule

// File: rtl/axi_read_controller.sv
// Unpacks AXI-Stream beats into one sorter item per cycle,
// skipping unkept lanes and stalling on a full sorter FIFO.
module axi_read_controller
  import axi_stream_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = AXIS_DW,
  parameter int C_SORTER_BIT_WIDTH = SORT_W
) (
  input  logic                            s_axis_aclk,
  input  logic                            s_axis_aresetn,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                            s_axis_tlast,
  input  logic                            fifo_in_full,
  output logic                            fifo_in_enq,
  output logic [C_SORTER_BIT_WIDTH-1:0]   fifo_in_item,
  output logic                            stream_done,
  output logic [31:0]                     item_count
);

  localparam int N  = C_AXIS_TDATA_WIDTH / C_SORTER_BIT_WIDTH;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = C_AXIS_TDATA_WIDTH / 8;
  localparam logic [PW-1:0] LAST_P = PW'(N - 1);

  rd_state_t r_state;
  rd_state_t w_state_nx;

  logic [C_AXIS_TDATA_WIDTH-1:0] r_data;
  logic [KW-1:0]                 r_keep;
  logic                          r_last;
  logic [PW-1:0]                 r_ptr;
  logic [PW-1:0]                 w_ptr_nx;
  logic                          r_done;
  logic [31:0]                   r_cnt;

  logic                          w_kept;
  logic [C_SORTER_BIT_WIDTH-1:0] w_item;
  logic                          w_unpack;
  logic                          w_stall;
  logic                          w_adv;
  logic                          w_end;
  logic                          w_rdy;
  logic                          w_acc;
  logic                          w_load;
  logic                          w_enq;

  axis_lane_select #(
    .DW (C_AXIS_TDATA_WIDTH),
    .SW (C_SORTER_BIT_WIDTH),
    .N  (N),
    .PW (PW)
  ) u_sel (
    .i_data (r_data),
    .i_keep (r_keep),
    .i_ptr  (r_ptr),
    .o_item (w_item),
    .o_kept (w_kept)
  );

  assign w_unpack = (r_state == ST_UNPACK);
  assign w_stall  = w_unpack && w_kept && fifo_in_full;
  assign w_adv    = w_unpack && !w_stall;
  assign w_end    = w_adv && (r_ptr == LAST_P);
  assign w_enq    = w_unpack && w_kept && !fifo_in_full;

  // Reset gates tready so it stays low for the whole reset window
  assign w_rdy = s_axis_aresetn &&
                 ((r_state == ST_IDLE) || w_end);
  assign w_acc = w_rdy && s_axis_tvalid;

  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_load     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_acc) begin
          w_load     = 1'b1;
          w_ptr_nx   = '0;
          w_state_nx = ST_UNPACK;
        end
      end
      ST_UNPACK: begin
        if (w_end) begin
          w_ptr_nx   = '0;
          w_load     = w_acc;
          w_state_nx = w_acc ? ST_UNPACK : ST_IDLE;
        end else if (w_adv) begin
          w_ptr_nx = r_ptr + PW'(1);
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
      if (w_load) begin
        r_data <= s_axis_tdata;
        r_keep <= s_axis_tkeep;
        r_last <= s_axis_tlast;
      end
    end
  end

  // The clear wins over a coinciding enqueue
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_done <= w_end && r_last;
      if (r_done) begin
        r_cnt <= '0;
      end else if (w_enq) begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end

  assign s_axis_tready = w_rdy;
  assign fifo_in_enq   = w_enq;
  assign fifo_in_item  = w_item;
  assign stream_done   = r_done;
  assign item_count    = r_cnt;

endmodule

// File: doc/axi_read_controller.md
AXI_READ_CONTROLLER -- requirements
Module: axi_read_controller

Interface
REQ-001 SHALL have parameter C_AXIS_TDATA_WIDTH, default 512, AXI-Stream data width in bits.
REQ-002 SHALL have parameter C_SORTER_BIT_WIDTH, default 128, sorter item width in bits; N = C_AXIS_TDATA_WIDTH/C_SORTER_BIT_WIDTH lanes per beat (default 4).
REQ-003 SHALL use one clock and an asynchronous, active-low reset:
- s_axis_aclk  in  1  clock; all state changes on its rising edge.
- s_axis_aresetn  in  1  reset; asynchronous assertion, active low.
REQ-004 SHALL have these remaining ports:
- s_axis_tvalid  in  1  upstream beat valid.
- s_axis_tready  out  1  beat accepted when tvalid and tready are both high.
- s_axis_tdata  in  C_AXIS_TDATA_WIDTH  beat payload; lane i = bits [(i+1)*C_SORTER_BIT_WIDTH-1 : i*C_SORTER_BIT_WIDTH].
- s_axis_tkeep  in  C_AXIS_TDATA_WIDTH/8  byte enables.
- s_axis_tlast  in  1  final beat of the stream.
- fifo_in_full  in  1  sorter input FIFO cannot accept an item.
- fifo_in_enq  out  1  enqueue strobe, one item per cycle.
- fifo_in_item  out  C_SORTER_BIT_WIDTH  item presented with fifo_in_enq.
- stream_done  out  1  one-cycle pulse when the last item of a tlast beat has been consumed.
- item_count  out  32  items enqueued since reset or since the last stream_done.

Function
REQ-005 SHALL implement FSM states IDLE and UNPACK.
REQ-006 SHALL hold s_axis_tready high in IDLE.
REQ-007 On acceptance in IDLE, SHALL register tdata, tkeep and tlast, clear lane pointer ptr to 0, and enter UNPACK.
REQ-008 Lane i is kept when any tkeep byte in lane i is 1; a lane with all-zero tkeep bytes SHALL NOT be enqueued.
REQ-009 In UNPACK, fifo_in_item SHALL equal registered lane ptr; fifo_in_enq = lane ptr kept AND NOT fifo_in_full (combinational).
REQ-010 ptr SHALL advance by 1 per cycle, except it holds while lane ptr is kept and fifo_in_full=1.
- Skipped lanes consume one cycle each.
- Kept lanes enqueue regardless of item value, zero included.
REQ-011 When ptr = N-1 and advances, s_axis_tready SHALL be high in that same cycle; otherwise it is low in UNPACK.
- If a beat is accepted then: register it, ptr := 0, stay in UNPACK.
- Otherwise: return to IDLE.
- Steady-state throughput is one beat per N cycles.
REQ-012 Latency: a beat accepted at edge k SHALL present lane 0 in cycle k+1.
REQ-013 stream_done SHALL pulse in the cycle after lane N-1 of a tlast beat advances, and SHALL also clear item_count in that cycle.
REQ-014 item_count SHALL increment by 1 per fifo_in_enq and wrap modulo 2^32.
- If an enqueue and the clear coincide, item_count SHALL become 0.
REQ-015 A tlast beat with all lanes unkept SHALL still produce stream_done after N cycles.
REQ-016 fifo_in_full rising mid-beat SHALL stall only at kept lanes; no item SHALL be dropped or duplicated.

Reset
REQ-017 While s_axis_aresetn=0, SHALL force:
- state IDLE, ptr 0;
- s_axis_tready 0, fifo_in_enq 0, fifo_in_item 0;
- stream_done 0, item_count 0;
- beat registers 0.
REQ-018 s_axis_tready SHALL first go high in the first cycle after reset deassertion.
REQ-019 Reset asserted mid-beat SHALL discard the buffered beat; no partial enqueue after release.

Structure
REQ-020 Package axi_stream_pkg SHALL hold the default widths, lane count N, the IDLE/UNPACK state encoding, and the lane-keep reduction function.
REQ-021 The lane-select mux (beat register + ptr -> item, keep bit) SHALL be a sub-module named axis_lane_select; all other logic stays in axi_read_controller.

Verification
REQ-022 Bench SHALL cover:
- Reset release, one beat of lanes 0x1,0x2,0x3,0x4 with full tkeep and tlast: enq in 4 consecutive cycles in that order; stream_done one cycle after; item_count 4 then 0.
- Back-to-back beats, tvalid held high: tready high once every 4 cycles; 8 items enqueued in order over 8 cycles.
- tkeep clearing lanes 1 and 3, items 0xA,0xB,0xC,0xD: only 0xA and 0xC enqueued; item_count 2.
- fifo_in_full high for 3 cycles while lane 2 is presented: lane 2 held, then enqueued exactly once; tready delayed by 3 cycles.
- s_axis_aresetn pulled low while ptr=1: all outputs 0 immediately; after release, tready=1 and no stale items enqueued.
- Zero-valued item 0x0 in a kept lane: enqueued; item_count increments.
